// File: rtl/doodle_pkg.sv
`default_nettype none
// ============================================================================
// Module  : doodle_pkg
// Brief   : Shared types and constants for the score-to-BCD display path.
// Rev     : 1.0  initial release
// ============================================================================
package doodle_pkg;

    localparam int SCORE_W_DEF = 20;
    localparam int DIGITS_DEF  = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_e;

    // Largest value representable in the given number of decimal digits.
    function automatic longint unsigned bcd_max(input int digits);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < digits; i++) begin
            r = r * 10;
        end
        return r - 1;
    endfunction

    localparam longint unsigned BCD_MAX = bcd_max(DIGITS_DEF);

endpackage
`default_nettype wire

// File: rtl/bcd_add3.sv
`default_nettype none
// ============================================================================
// Module  : bcd_add3
// Brief   : Double-dabble nibble correction: adds 3 when the nibble is >= 5.
// Rev     : 1.0  initial release
// ============================================================================
module bcd_add3 (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);

    assign o_nib = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;

endmodule
`default_nettype wire

// File: rtl/score_bcd.sv
`default_nettype none
// ============================================================================
// Module  : score_bcd
// Brief   : Sequential binary-to-BCD converter for the score display; converts
//           only when the score changes and saturates at all nines.
//           Optional leading-zero blanking: define SCORE_BCD_BLANK_EN.
// Rev     : 1.0  initial release
// ============================================================================
module score_bcd
    import doodle_pkg::*;
#(
    parameter int SCORE_W = SCORE_W_DEF,
    parameter int DIGITS  = DIGITS_DEF
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic [SCORE_W-1:0]    Score,
    output logic [4*DIGITS-1:0]   Digits,
    output logic                  Overflow,
    output logic                  Busy,
    output logic                  Valid,
    output logic [DIGITS-1:0]     Blank
);

    localparam int              BW          = 4 * DIGITS;
    localparam int              CNT_W       = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
    localparam logic [63:0]     C_BCD_LIMIT = 64'(bcd_max(DIGITS));
    localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(SCORE_W - 1);

    state_e               state_q,  state_d;
    logic [SCORE_W-1:0]   last_q,   last_d;
    logic [SCORE_W-1:0]   cap_q,    cap_d;
    logic [SCORE_W-1:0]   bin_q,    bin_d;
    logic [BW-1:0]        bcd_q,    bcd_d;
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    logic                 sat_q,    sat_d;
    logic [BW-1:0]        digits_q, digits_d;
    logic                 ovf_q,    ovf_d;
    logic                 busy_q,   busy_d;
    logic                 valid_q,  valid_d;
    logic [BW-1:0]        bcd_adj;
    logic                 in_range;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_add3
            bcd_add3 u_add3 (
                .i_nib (bcd_q[4*gi +: 4]),
                .o_nib (bcd_adj[4*gi +: 4])
            );
        end
    endgenerate

    assign in_range = (64'(Score) <= C_BCD_LIMIT);

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        cap_d    = cap_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        sat_d    = sat_q;
        digits_d = digits_q;
        ovf_d    = ovf_q;
        valid_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Score != last_q) begin
                    cap_d = Score;
                    if (in_range) begin
                        bin_d   = Score;
                        bcd_d   = '0;
                        cnt_d   = '0;
                        sat_d   = 1'b0;
                        state_d = ST_SHIFT;
                    end else begin
                        sat_d   = 1'b1;
                        state_d = ST_LATCH;
                    end
                end
            end
            ST_SHIFT: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == C_LAST_CNT) begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                digits_d = sat_q ? {DIGITS{4'h9}} : bcd_q;
                ovf_d    = sat_q;
                valid_d  = 1'b1;
                last_d   = cap_q;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q  <= ST_IDLE;
            last_q   <= '0;
            cap_q    <= '0;
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            sat_q    <= 1'b0;
            digits_q <= '0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            cap_q    <= cap_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            sat_q    <= sat_d;
            digits_q <= digits_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
        end
    end

    assign Digits   = digits_q;
    assign Overflow = ovf_q;
    assign Busy     = busy_q;
    assign Valid    = valid_q;

`ifdef SCORE_BCD_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d;
    logic              blank_run;

    // Bit i blanks digit i when it and every digit above it are zero.
    always_comb begin
        blank_d   = blank_q;
        blank_run = 1'b1;
        if (state_q == ST_LATCH) begin
            blank_d = '0;
            if (!sat_q) begin
                for (int i = DIGITS - 1; i >= 1; i--) begin
                    blank_run  = blank_run && (bcd_q[4*i +: 4] == 4'd0);
                    blank_d[i] = blank_run;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            blank_q <= {{(DIGITS-1){1'b1}}, 1'b0};
        end else begin
            blank_q <= blank_d;
        end
    end

    assign Blank = blank_q;
`else
    assign Blank = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_score_bcd.sv
`default_nettype none
// ============================================================================
// Module  : tb_score_bcd
// Brief   : Self-checking bench for score_bcd against a decimal reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_score_bcd;

    localparam int SW   = 20;
    localparam int DG   = 6;
    localparam int MAXV = 999999;

    logic            Clk = 1'b0;
    logic            Reset_n;
    logic [SW-1:0]   Score;
    logic [4*DG-1:0] Digits;
    logic            Overflow;
    logic            Busy;
    logic            Valid;
    logic [DG-1:0]   Blank;

    int n_checks = 0;
    int n_errors = 0;

    score_bcd #(.SCORE_W(SW), .DIGITS(DG)) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .Score    (Score),
        .Digits   (Digits),
        .Overflow (Overflow),
        .Busy     (Busy),
        .Valid    (Valid),
        .Blank    (Blank)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Decimal digits of v, or all nines when v does not fit.
    function automatic logic [4*DG-1:0] ref_digits(input int unsigned v);
        logic [4*DG-1:0] r;
        int unsigned     x;
        r = '0;
        x = v;
        if (v > MAXV) return {DG{4'h9}};
        for (int i = 0; i < DG; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [DG-1:0] ref_blank(input int unsigned v);
        logic [DG-1:0] r;
        int unsigned   p;
        r = '0;
`ifdef SCORE_BCD_BLANK_EN
        p = 10;
        if (v <= MAXV) begin
            for (int i = 1; i < DG; i++) begin
                r[i] = (v < p);
                p = p * 10;
            end
        end
`else
        p = v;
`endif
        return r;
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Waits for the Valid pulse of a conversion whose capture edge is the next one.
    task automatic wait_valid(input string tag, input int unsigned v,
                              input int chg_at, input logic [SW-1:0] chg_val);
        int              n;
        int              exp_lat;
        bit              got;
        bit              stable;
        logic [4*DG-1:0] prev;
        n       = 0;
        got     = 1'b0;
        stable  = 1'b1;
        prev    = Digits;
        exp_lat = (v > MAXV) ? 2 : SW + 2;
        while (!got && n < 64) begin
            step();
            n++;
            if (n == 1) chk({tag, " busy_rise"}, 64'(Busy), 64'd1);
            if (Valid) got = 1'b1;
            else if (Digits !== prev) stable = 1'b0;
            if (n == chg_at) Score = chg_val;
        end
        chk({tag, " latency"}, 64'(n), 64'(exp_lat));
        chk({tag, " digits"}, 64'(Digits), 64'(ref_digits(v)));
        chk({tag, " overflow"}, 64'(Overflow), 64'(v > MAXV));
        chk({tag, " busy_idle"}, 64'(Busy), 64'd0);
        chk({tag, " stable"}, 64'(stable), 64'd1);
        chk({tag, " blank"}, 64'(Blank), 64'(ref_blank(v)));
    endtask

    initial begin
        int          vcount;
        int unsigned cur;
        int unsigned v;
        int unsigned w;
        int          at;

        Reset_n = 1'b0;
        Score   = '0;
        step();
        step();
        chk("reset digits", 64'(Digits), 64'd0);
        chk("reset busy", 64'(Busy), 64'd0);
        chk("reset valid", 64'(Valid), 64'd0);
        chk("reset overflow", 64'(Overflow), 64'd0);
        chk("reset blank", 64'(Blank), 64'(ref_blank(0)));
        Reset_n = 1'b1;
        vcount  = 0;
        repeat (6) begin
            step();
            if (Valid) vcount++;
        end
        chk("idle zero no valid", 64'(vcount), 64'd0);
        chk("idle zero busy", 64'(Busy), 64'd0);

        Score = SW'(1234);
        wait_valid("s1234", 1234, 0, '0);
        step();
        chk("s1234 pulse width", 64'(Valid), 64'd0);

        Score = SW'(500);
        wait_valid("s500", 500, 11, SW'(700));
        wait_valid("s700", 700, 0, '0);

        Score  = SW'(MAXV);
        vcount = 0;
        repeat (6) begin
            step();
            if (Valid) vcount++;
        end
        Reset_n = 1'b0;
        step();
        if (Valid) vcount++;
        chk("abort no valid", 64'(vcount), 64'd0);
        chk("abort digits", 64'(Digits), 64'd0);
        chk("abort busy", 64'(Busy), 64'd0);
        Reset_n = 1'b1;
        wait_valid("redo", MAXV, 0, '0);

        Score = SW'(1048575);
        wait_valid("sat", 1048575, 0, '0);
        cur = 1048575;

        repeat (10) begin
            do begin
                if ($urandom_range(0, 3) == 0) v = $urandom_range(1000000, 1048575);
                else                           v = $urandom_range(1, MAXV);
            end while (v == cur || v == 305);
            Score = SW'(v);
            if (v <= MAXV && $urandom_range(0, 1) == 1) begin
                do w = $urandom_range(1, MAXV); while (w == v || w == 305);
                at = $urandom_range(2, 21);
                wait_valid("rnd", v, at, SW'(w));
                wait_valid("rnd_chg", w, 0, '0);
                cur = w;
            end else begin
                wait_valid("rnd", v, 0, '0);
                cur = v;
            end
        end

        Score = SW'(305);
        wait_valid("s305", 305, 0, '0);
        Score = '0;
        wait_valid("s0", 0, 0, '0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
